// File: rtl/aes_enc_stream_pkg.sv
// aes_pkg: shared AES-128 constants and byte-level helpers for the
// aes_enc_stream engine (S-box table, round constants, GF(2^8) doubling,
// FSM state type).
package aes_pkg;

  localparam logic [3:0] AES_NR = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_enc_stream_if.sv
// aes_enc_stream_if: key load, plaintext input and ciphertext FIFO
// handshakes of the aes_enc_stream engine.
// Optional macro AES_BLK_CNT_EN adds the blk_cnt signal and CNT_W parameter.
interface aes_enc_stream_if #(
  parameter int FIFO_DEPTH = 4
`ifdef AES_BLK_CNT_EN
  , parameter int CNT_W = 16
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [127:0]  key;
  logic          key_valid;
  logic          key_ready;
  logic [127:0]  data_in;
  logic          valid_in;
  logic          ready_in;
  logic [127:0]  data_out;
  logic          valid_out;
  logic          fifo_rd_en;
  logic [CW-1:0] fifo_count;
`ifdef AES_BLK_CNT_EN
  logic [CNT_W-1:0] blk_cnt;
`endif

  modport master (
    output key, key_valid, data_in, valid_in, fifo_rd_en,
    input  key_ready, ready_in, data_out, valid_out, fifo_count
`ifdef AES_BLK_CNT_EN
    , input blk_cnt
`endif
  );

  modport slave (
    input  key, key_valid, data_in, valid_in, fifo_rd_en,
    output key_ready, ready_in, data_out, valid_out, fifo_count
`ifdef AES_BLK_CNT_EN
    , output blk_cnt
`endif
  );

endinterface

// File: rtl/aes_enc_stream_out_fifo.sv
// aes_out_fifo: show-ahead ciphertext FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module aes_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push_i && (count_q != FULL_CNT);
  assign do_pop  = pop_i && (count_q != '0);

  // Pointer and occupancy next-state; a pop on an empty FIFO does nothing.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; cleared on reset so the head reads zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/aes_enc_stream.sv
// aes_enc_stream: iterative AES-128 encryptor, one round per clock with
// on-the-fly key expansion, feeding a show-ahead ciphertext FIFO.
// Optional macro AES_BLK_CNT_EN adds a wrapping count of FIFO pushes (blk_cnt).
module aes_enc_stream
  import aes_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input logic             clk,
  input logic             rst_n,
  aes_enc_stream_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("aes_enc_stream: FIFO_DEPTH must be a power of two and at least 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("aes_enc_stream: CNT_W must be at least 1");
  end

  // SubBytes followed by ShiftRows; byte i sits at row i%4, column i/4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = sbox(s[127-8*(4*((c+row)%4)+row) -: 8]);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // One step of the AES-128 key schedule: RotWord, SubWord, Rcon on w3.
  function automatic logic [127:0] key_next(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_e         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   st_q, st_d;
  logic [127:0]   rk_q, rk_d;
  logic [3:0]     rnd_q, rnd_d;
  logic           rdy_en_q;
  logic           push;
  logic           accept;
  logic           key_load;
  logic [127:0]   active_key;
  logic [7:0]     rcon;
  logic [127:0]   rk_next;
  logic [127:0]   ss;
  logic [127:0]   round_out;
  logic [CW-1:0]  fifo_cnt;

  assign bus.key_ready = (state_q == IDLE);
  // ready_in stays low through reset and rises on the first edge after release.
  assign bus.ready_in  = rdy_en_q && (state_q == IDLE) && (fifo_cnt < FULL_CNT);
  assign accept        = bus.valid_in && bus.ready_in;
  assign key_load      = bus.key_valid && bus.key_ready;
  // A key loaded in the same cycle as a block is already the key for that block.
  assign active_key    = key_load ? bus.key : key_q;

  assign rcon      = (rnd_q >= 4'd1 && rnd_q <= AES_NR) ? RCON[rnd_q - 4'd1] : 8'h00;
  assign rk_next   = key_next(rk_q, rcon);
  assign ss        = sub_shift(st_q);
  assign round_out = ((rnd_q == AES_NR) ? ss : mix_columns(ss)) ^ rk_next;

  // Next-state and datapath control for the IDLE/RUN engine.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    st_d    = st_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    push    = 1'b0;
    if (key_load) key_d = bus.key;
    case (state_q)
      IDLE: begin
        if (accept) begin
          st_d    = bus.data_in ^ active_key;
          rk_d    = active_key;
          rnd_d   = 4'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        st_d  = round_out;
        rk_d  = rk_next;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == AES_NR) begin
          push    = 1'b1;
          rnd_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register and the post-reset input enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Key, cipher state, round key and round counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      st_q  <= '0;
      rk_q  <= '0;
      rnd_q <= '0;
    end else begin
      key_q <= key_d;
      st_q  <= st_d;
      rk_q  <= rk_d;
      rnd_q <= rnd_d;
    end
  end

  aes_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (128)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (round_out),
    .pop_i   (bus.fifo_rd_en),
    .dout_o  (bus.data_out),
    .valid_o (bus.valid_out),
    .count_o (fifo_cnt)
  );

  assign bus.fifo_count = fifo_cnt;

`ifdef AES_BLK_CNT_EN
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

  assign blk_cnt_d = push ? blk_cnt_q + CNT_W'(1) : blk_cnt_q;

  // Completed-block counter, wraps at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blk_cnt_q <= '0;
    else        blk_cnt_q <= blk_cnt_d;
  end

  assign bus.blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_enc_stream.sv
// Directed bench for aes_enc_stream using FIPS-197 vectors.
// With AES_BLK_CNT_EN defined the block counter is built with CNT_W=2.
module tb_aes_enc_stream;

  localparam int DEPTH = 4;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KJ = 128'hffeeddccbbaa99887766554433221100;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

`ifdef AES_BLK_CNT_EN
  aes_enc_stream_if #(.FIFO_DEPTH(DEPTH), .CNT_W(2)) bus ();
  aes_enc_stream #(.FIFO_DEPTH(DEPTH), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
`else
  aes_enc_stream_if #(.FIFO_DEPTH(DEPTH)) bus ();
  aes_enc_stream #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.key        = '0;
    bus.key_valid  = 1'b0;
    bus.data_in    = '0;
    bus.valid_in   = 1'b0;
    bus.fifo_rd_en = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic pop_one();
    bus.fifo_rd_en = 1'b1;
    step();
    bus.fifo_rd_en = 1'b0;
  endtask

  // Offers one block and returns just after the edge that accepted it.
  task automatic offer(input logic ld, input logic [127:0] k, input logic [127:0] pt,
                       output bit ok);
    ok            = 1'b0;
    bus.key       = k;
    bus.key_valid = ld;
    bus.data_in   = pt;
    bus.valid_in  = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.ready_in === 1'b1) ok = 1'b1;
      step();
    end
    bus.valid_in  = 1'b0;
    bus.key_valid = 1'b0;
  endtask

  task automatic wait_count(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (int'(bus.fifo_count) == n) ok = 1'b1;
      else step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    n_vec++;
    if ({bus.key_ready, bus.ready_in, bus.valid_out} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_flags: got kr/ri/vo=%b, want 100", {bus.key_ready, bus.ready_in, bus.valid_out});
    end
    n_vec++;
    if (bus.data_out !== 128'h0 || bus.fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL reset_fifo: got data_out=%h count=%0d, want 0 and 0", bus.data_out, bus.fifo_count);
    end
`ifdef AES_BLK_CNT_EN
    n_vec++;
    if (bus.blk_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL reset_blk_cnt: got %0d, want 0", bus.blk_cnt);
    end
`endif
    step();
    step();
    #2 rst_n = 1'b1;
    n_vec++;
    if (bus.ready_in !== 1'b0) begin
      n_err++;
      $display("FAIL ready_before_edge: got %b, want 0", bus.ready_in);
    end
    step();
    n_vec++;
    if (bus.ready_in !== 1'b1 || bus.key_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_edge: got ri=%b kr=%b, want 1 1", bus.ready_in, bus.key_ready);
    end
  endtask

  task automatic test_c1();
    bit ok;
    bit early;
    offer(1'b1, K1, P1, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL c1_accept: got timeout, want accept");
    end
    early = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (bus.valid_out !== 1'b0 || bus.key_ready !== 1'b0) early = 1'b1;
    end
    n_vec++;
    if (early) begin
      n_err++;
      $display("FAIL c1_busy: got valid_out or key_ready high during rounds, want both low");
    end
    step();
    n_vec++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== C1) begin
      n_err++;
      $display("FAIL c1_result: got vo=%b data=%h, want 1 %h", bus.valid_out, bus.data_out, C1);
    end
    n_vec++;
    if (bus.key_ready !== 1'b1 || bus.fifo_count !== 3'd1) begin
      n_err++;
      $display("FAIL c1_idle: got kr=%b count=%0d, want 1 1", bus.key_ready, bus.fifo_count);
    end
    pop_one();
    pop_one();
    n_vec++;
    if (bus.valid_out !== 1'b0 || bus.fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL empty_pop: got vo=%b count=%0d, want 0 0", bus.valid_out, bus.fifo_count);
    end
  endtask

  task automatic test_fips_b();
    bit ok;
    offer(1'b1, KB, PB, ok);
    wait_count(1, ok);
    n_vec++;
    if (!ok || bus.data_out !== CB) begin
      n_err++;
      $display("FAIL fips_b: got ok=%b data=%h, want 1 %h", ok, bus.data_out, CB);
    end
    pop_one();
  endtask

  task automatic test_backpressure();
    int  acc;
    bit  ok;
    bit  bad;
    acc           = 0;
    bus.key       = K1;
    bus.key_valid = 1'b1;
    bus.data_in   = P1;
    bus.valid_in  = 1'b1;
    for (int i = 0; i < 70; i++) begin
      if (bus.ready_in === 1'b1) acc++;
      step();
    end
    n_vec++;
    if (acc != 4 || bus.ready_in !== 1'b0 || bus.fifo_count !== 3'd4) begin
      n_err++;
      $display("FAIL bp_fill: got acc=%0d ri=%b count=%0d, want 4 0 4", acc, bus.ready_in, bus.fifo_count);
    end
    pop_one();
    n_vec++;
    if (bus.ready_in !== 1'b1 || bus.fifo_count !== 3'd3) begin
      n_err++;
      $display("FAIL bp_pop: got ri=%b count=%0d, want 1 3", bus.ready_in, bus.fifo_count);
    end
    step();
    n_vec++;
    if (bus.key_ready !== 1'b0 || bus.ready_in !== 1'b0) begin
      n_err++;
      $display("FAIL bp_reaccept: got kr=%b ri=%b, want 0 0", bus.key_ready, bus.ready_in);
    end
    bus.valid_in  = 1'b0;
    bus.key_valid = 1'b0;
    wait_count(4, ok);
    bad = !ok;
    for (int j = 0; j < 4; j++) begin
      if (bus.valid_out !== 1'b1 || bus.data_out !== C1) bad = 1'b1;
      pop_one();
    end
    n_vec++;
    if (bad || bus.valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: got bad=%b vo=%b head=%h, want 0 0 with %h each pop", bad, bus.valid_out, bus.data_out, C1);
    end
  endtask

  task automatic test_key_switch();
    bit          ok;
    logic [127:0] exp [4];
    exp = '{CB, CB, C1, C1};
    offer(1'b1, KB, PB, ok);
    bus.key       = KJ;
    bus.key_valid = 1'b1;
    step();
    step();
    n_vec++;
    if (bus.key_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ks_busy: got key_ready=%b, want 0", bus.key_ready);
    end
    step();
    bus.key_valid = 1'b0;
    offer(1'b0, KJ, PB, ok);
    offer(1'b1, K1, P1, ok);
    offer(1'b0, KB, P1, ok);
    wait_count(4, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL ks_fill: got count=%0d, want 4", bus.fifo_count);
    end
    for (int j = 0; j < 4; j++) begin
      n_vec++;
      if (bus.data_out !== exp[j]) begin
        n_err++;
        $display("FAIL ks_out%0d: got %h, want %h", j, bus.data_out, exp[j]);
      end
      pop_one();
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit stale;
    offer(1'b1, KB, PB, ok);
    wait_count(1, ok);
    offer(1'b1, K1, P1, ok);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.valid_out, bus.key_ready, bus.ready_in} !== 3'b010 || bus.fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL rst_mid: got vo/kr/ri=%b count=%0d, want 010 0", {bus.valid_out, bus.key_ready, bus.ready_in}, bus.fifo_count);
    end
    step();
    step();
    #2 rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.valid_out !== 1'b0) stale = 1'b1;
    end
    n_vec++;
    if (stale) begin
      n_err++;
      $display("FAIL rst_stale: got valid_out=1 after reset, want 0");
    end
    offer(1'b1, K1, P1, ok);
    wait_count(1, ok);
    n_vec++;
    if (!ok || bus.data_out !== C1) begin
      n_err++;
      $display("FAIL rst_resend: got ok=%b data=%h, want 1 %h", ok, bus.data_out, C1);
    end
    pop_one();
  endtask

  task automatic test_push_pop();
    bit ok;
    offer(1'b1, KB, PB, ok);
    wait_count(1, ok);
    offer(1'b1, K1, P1, ok);
    wait_count(2, ok);
    offer(1'b1, K1, P1, ok);
    repeat (9) step();
    bus.fifo_rd_en = 1'b1;
    step();
    bus.fifo_rd_en = 1'b0;
    n_vec++;
    if (bus.fifo_count !== 3'd2 || bus.data_out !== C1) begin
      n_err++;
      $display("FAIL push_pop: got count=%0d head=%h, want 2 %h", bus.fifo_count, bus.data_out, C1);
    end
    pop_one();
    n_vec++;
    if (bus.fifo_count !== 3'd1 || bus.data_out !== C1) begin
      n_err++;
      $display("FAIL push_pop_tail: got count=%0d head=%h, want 1 %h", bus.fifo_count, bus.data_out, C1);
    end
    pop_one();
  endtask

`ifdef AES_BLK_CNT_EN
  task automatic test_blk_cnt();
    bit         ok;
    logic [1:0] exp [5];
    exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      offer(1'b1, K1, P1, ok);
      wait_count(1, ok);
      n_vec++;
      if (!ok || bus.blk_cnt !== exp[k]) begin
        n_err++;
        $display("FAIL blk_cnt%0d: got %0d, want %0d", k, bus.blk_cnt, exp[k]);
      end
      pop_one();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_c1();
    test_fips_b();
    test_backpressure();
    test_key_switch();
    test_reset_mid();
    test_push_pop();
`ifdef AES_BLK_CNT_EN
    test_blk_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
